// File: rtl/seg_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared constants, glyph table and converter state type for
//               the eight-digit seven-segment scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam int NUM_DIGITS  = 8;
    localparam int BANK_DIGITS = 4;

    // Segment bit positions within {a,b,c,d,e,f,g,dp}
    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    localparam logic [7:0] SEG_DP_MASK = 8'b1 << SEG_DP;
    localparam logic [7:0] GLYPH_BLANK = 8'h00;

    localparam logic [7:0] GLYPH [0:15] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

endpackage
`default_nettype wire

// File: rtl/seg_scan_driver_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble, 32-bit binary to 10 BCD digits,
//               one input bit per cycle; start restarts from any state.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] bin,
    output logic        busy,
    output logic        done,
    output logic [39:0] bcd
);

    conv_state_t r_state, w_state_nxt;
    logic [4:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_sh, w_sh_nxt;
    logic [39:0] r_acc, w_acc_nxt;
    logic [38:0] w_adj;

    // Top digit is at most 2 before any shift of a 32-bit input, so it never
    // needs the +3 correction; only its low three bits survive the shift.
    always_comb begin
        w_adj = r_acc[38:0];
        for (int n = 0; n < 9; n++) begin
            if (r_acc[4*n +: 4] >= 4'd5) begin
                w_adj[4*n +: 4] = r_acc[4*n +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sh_nxt    = r_sh;
        w_acc_nxt   = r_acc;
        case (r_state)
            SHIFT: begin
                w_acc_nxt = {w_adj, r_sh[31]};
                w_sh_nxt  = {r_sh[30:0], 1'b0};
                w_cnt_nxt = r_cnt + 5'd1;
                if (r_cnt == 5'd31) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = r_state;
        endcase
        if (start) begin
            w_state_nxt = SHIFT;
            w_cnt_nxt   = 5'd0;
            w_sh_nxt    = bin;
            w_acc_nxt   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sh    <= w_sh_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);
    assign bcd  = r_acc;

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Eight-digit multiplexed seven-segment driver, hex or decimal.
//               Define SEG_LZ_BLANK_EN to blank leading zero digits.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic        load,
    input  logic        base,
    output logic [7:0]  digit_en,
    output logic [7:0]  sseg,
    output logic [7:0]  sseg1,
    output logic        busy
);

    localparam logic [23:0] c_div_max = 24'(SCAN_DIV - 1);
    localparam logic [7:0]  c_en_base = 8'h11;

    logic [31:0] r_val, r_bcd;
    logic        r_base_q, r_ovf;
    logic [23:0] r_div;
    logic [1:0]  r_slot;
    logic [7:0]  r_digit_en, r_sseg, r_sseg1;

    logic        w_start, w_tick, w_conv_done, w_ovf_dp;
    logic [31:0] w_val_next, w_src;
    logic [39:0] w_conv_bcd;
    logic [7:0]  w_seg [NUM_DIGITS];

    // The converter captures the value being latched this cycle, not the old one
    assign w_start    = load | (base ^ r_base_q);
    assign w_val_next = load ? data : r_val;
    assign w_tick     = (r_div == c_div_max);
    assign w_src      = r_base_q ? r_bcd : r_val;
    assign w_ovf_dp   = r_base_q & r_ovf;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .bin   (w_val_next),
        .busy  (busy),
        .done  (w_conv_done),
        .bcd   (w_conv_bcd)
    );

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        logic [3:0] w_nib;
        logic       w_blank;
        assign w_nib = w_src[4*k +: 4];
`ifdef SEG_LZ_BLANK_EN
        if (k == 0) begin : g_keep
            assign w_blank = 1'b0;
        end else begin : g_lz
            assign w_blank = ~|w_src[31:4*k];
        end
`else
        assign w_blank = 1'b0;
`endif
        if (k == NUM_DIGITS - 1) begin : g_msd
            assign w_seg[k] = (w_blank ? GLYPH_BLANK : GLYPH[w_nib])
                            | (w_ovf_dp ? SEG_DP_MASK : 8'h00);
        end else begin : g_rest
            assign w_seg[k] = w_blank ? GLYPH_BLANK : GLYPH[w_nib];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val      <= '0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
            r_base_q   <= 1'b0;
            r_div      <= '0;
            r_slot     <= '0;
            r_digit_en <= '0;
            r_sseg     <= '0;
            r_sseg1    <= '0;
        end else begin
            r_base_q <= base;
            if (load) begin
                r_val <= data;
            end
            if (w_conv_done) begin
                r_bcd <= w_conv_bcd[31:0];
                r_ovf <= |w_conv_bcd[39:32];
            end
            // Outputs show the slot that was current at the tick, then advance
            if (w_tick) begin
                r_div      <= '0;
                r_slot     <= r_slot + 2'd1;
                r_digit_en <= c_en_base << r_slot;
                r_sseg     <= w_seg[{1'b1, r_slot}];
                r_sseg1    <= w_seg[{1'b0, r_slot}];
            end else begin
                r_div <= r_div + 24'd1;
            end
        end
    end

    assign digit_en = r_digit_en;
    assign sseg     = r_sseg;
    assign sseg1    = r_sseg1;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_seg_scan_driver
// Description : Scoreboard bench for seg_scan_driver with an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int SD = 4;
    localparam logic [7:0] GL [0:15] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    typedef struct {
        logic [7:0] en;
        logic [7:0] seg;
        logic [7:0] seg1;
        string      tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        base = 1'b0;
    logic [31:0] data = '0;
    logic [7:0]  digit_en, sseg, sseg1;
    logic        busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc;
    exp_t q[$];
    exp_t mon_e;

    seg_scan_driver #(.SCAN_DIV(SD)) dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .load     (load),
        .base     (base),
        .digit_en (digit_en),
        .sseg     (sseg),
        .sseg1    (sseg1),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: digit k of the value in the selected radix, from plain arithmetic
    function automatic logic [7:0] model_seg(input logic [31:0] v, input bit dec, input int k);
        longint unsigned src, radix, p;
        logic [7:0] s;
        radix = dec ? 64'd10 : 64'd16;
        src   = dec ? (64'(v) % 64'd100000000) : 64'(v);
        p     = 1;
        for (int j = 0; j < k; j++) p = p * radix;
        s = GL[int'((src / p) % radix)];
`ifdef SEG_LZ_BLANK_EN
        if (k > 0 && (src / p) == 0) s = 8'h00;
`endif
        if (k == 7 && dec && 64'(v) >= 64'd100000000) s = s | 8'h01;
        return s;
    endfunction

    // Monitor: every slot tick presents a new frame entry
    always @(negedge clk) begin
        if (!rst && cyc > 0 && (cyc % SD) == 0 && q.size() > 0) begin
            mon_e = q.pop_front();
            chk({mon_e.tag, ".digit_en"}, 32'(digit_en), 32'(mon_e.en));
            chk({mon_e.tag, ".sseg"},     32'(sseg),     32'(mon_e.seg));
            chk({mon_e.tag, ".sseg1"},    32'(sseg1),    32'(mon_e.seg1));
        end
    end

    task automatic do_load(input logic [31:0] v, input bit b);
        @(negedge clk);
        data = v;
        load = 1'b1;
        base = b;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic settle();
        int t;
        t = 0;
        while (busy && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (busy) chk("settle_timeout", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic expect_frame(input logic [31:0] v, input bit dec, input string tag);
        int   t;
        exp_t e;
        t = 0;
        while (!((cyc % SD) != 0 && ((cyc / SD) % 4) == 0) && t < 20 * SD) begin
            t++;
            @(negedge clk);
        end
        for (int s = 0; s < 4; s++) begin
            e.en   = 8'h11 << s;
            e.seg  = model_seg(v, dec, s + 4);
            e.seg1 = model_seg(v, dec, s);
            e.tag  = $sformatf("%s[%0h,s%0d]", tag, v, s);
            q.push_back(e);
        end
        t = 0;
        while (q.size() > 0 && t < 8 * SD) begin
            t++;
            @(negedge clk);
        end
        if (q.size() > 0) begin
            chk({tag, ".frame_timeout"}, 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [31:0] v;
        bit          b;

        repeat (3) @(negedge clk);
        chk("reset.digit_en", 32'(digit_en), 32'd0);
        chk("reset.sseg",     32'(sseg),     32'd0);
        chk("reset.sseg1",    32'(sseg1),    32'd0);
        chk("reset.busy",     32'(busy),     32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("pre_first_tick.digit_en", 32'(digit_en), 32'd0);
        expect_frame(32'd0, 1'b0, "reset_frame");

        do_load(32'h1234ABCD, 1'b0);
        settle();
        expect_frame(32'h1234ABCD, 1'b0, "hex");

        do_load(32'd0, 1'b1);
        settle();
        do_load(32'd12345678, 1'b1);
        count_busy(n);
        chk("busy_len_dec", 32'(n), 32'd33);
        settle();
        expect_frame(32'd12345678, 1'b1, "dec");

        do_load(32'hFFFFFFFF, 1'b1);
        settle();
        expect_frame(32'hFFFFFFFF, 1'b1, "ovf");
        do_load(32'd5, 1'b1);
        settle();
        expect_frame(32'd5, 1'b1, "ovf_clear");

        do_load(32'd99, 1'b1);
        repeat (9) @(negedge clk);
        do_load(32'd42, 1'b1);
        count_busy(n);
        chk("busy_len_restart", 32'(n), 32'd33);
        settle();
        expect_frame(32'd42, 1'b1, "restart");

        do_load(32'd777777, 1'b1);
        repeat (7) @(negedge clk);
        base = 1'b0;
        @(negedge clk);
        base = 1'b1;
        @(negedge clk);
        count_busy(n);
        chk("busy_len_base_toggle", 32'(n), 32'd33);
        settle();
        expect_frame(32'd777777, 1'b1, "base_toggle");

        do_load(32'h00000A00, 1'b0);
        count_busy(n);
        chk("busy_len_load_and_base", 32'(n), 32'd33);
        settle();
        expect_frame(32'h00000A00, 1'b0, "lz_pattern");

        for (int i = 0; i < 10; i++) begin
            v = (i % 3 == 0) ? 32'($urandom_range(0, 9999)) : $urandom;
            b = 1'($urandom_range(0, 1));
            do_load(v, b);
            settle();
            expect_frame(v, b, "random");
        end

        do_load(32'd87654321, 1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset.busy",     32'(busy),     32'd0);
        chk("midreset.digit_en", 32'(digit_en), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        expect_frame(32'd0, 1'b1, "post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
